// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush scheduler.
// Holds the FSM state encoding, the per-register control vectors and the load-use hazard helper.
package pipe_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MC_WAIT  = 2'd2
  } state_e;

  // Vector layout: [3:0] stall IF/ID, ID/EX, EX/MEM, MEM/WB; [7:4] flush in the same order
  localparam logic [7:0] CTRL_IDLE    = 8'h00;
  localparam logic [7:0] CTRL_LDUSE   = 8'h21;
  localparam logic [7:0] CTRL_REDIR   = 8'h30;
  localparam logic [7:0] CTRL_MCWAIT  = 8'h43;
  localparam logic [7:0] CTRL_MEMWAIT = 8'h87;
  localparam logic [7:0] CTRL_RESET   = 8'hF0;

  function automatic logic is_load_use(input logic       ex_load,
                                       input logic [4:0] ex_rd,
                                       input logic [4:0] rs1,
                                       input logic [4:0] rs2);
    return ex_load && (ex_rd != 5'd0) && ((ex_rd == rs1) || (ex_rd == rs2));
  endfunction

endpackage

// File: rtl/pipe_stall_ctrl_perf_cnt.sv
// Saturating event counter used for the stall/flush performance statistics.
// Only compiled into the design when PIPE_STALL_CTRL_PERF_EN is defined.
`ifdef PIPE_STALL_CTRL_PERF_EN
module pipe_stall_ctrl_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush scheduler for the 5-stage RV32 pipeline (load-use, redirect, mul/div, dmem wait).
// Define PIPE_STALL_CTRL_PERF_EN to add the stall-cycle and flush-event performance counters.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MEM_TMO = 16
`ifdef PIPE_STALL_CTRL_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ex_jump,
  input  logic       branch_take,
  input  logic       ex_load,
  input  logic [4:0] ex_rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       mc_start,
  input  logic       mc_done,
  input  logic       dmem_req,
  input  logic       dmem_ack,
  output logic       pc_pause,
  output logic [7:0] pipe_ctrl,
  output logic       mem_timeout,
  output logic [1:0] st_dbg
`ifdef PIPE_STALL_CTRL_PERF_EN
  , output logic [CNT_W-1:0] perf_stall_cyc
  , output logic [CNT_W-1:0] perf_flush_cnt
`endif
);

  localparam int TMR_W = (MEM_TMO > 2) ? $clog2(MEM_TMO) : 1;

  state_e           state, state_nxt;
  logic             mc_busy;
  logic [TMR_W-1:0] timer, timer_nxt;

  logic in_mem, mem_req_stall, mem_row, mc_row, redir_row, lduse_row;
  logic tmo_hit, mem_stay;

  assign in_mem        = (state == ST_MEM_WAIT);
  assign mem_req_stall = dmem_req & ~dmem_ack;
  assign mem_row       = mem_req_stall | (in_mem & ~dmem_ack);
  // Equal to the next value of mc_busy: done always wins over a fresh start
  assign mc_row        = (mc_start | mc_busy) & ~mc_done;
  assign redir_row     = branch_take | ex_jump;
  assign lduse_row     = is_load_use(ex_load, ex_rd, rs1, rs2);

  generate
    if (MEM_TMO == 0) begin : g_no_tmo
      assign tmo_hit = 1'b0;
    end else begin : g_tmo
      assign tmo_hit = in_mem & ~dmem_ack & (timer == TMR_W'(MEM_TMO - 1));
    end
  endgenerate

  assign mem_stay = in_mem ? (~dmem_ack & ~tmo_hit) : mem_req_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_RUN;
      mc_busy <= 1'b0;
      timer   <= '0;
    end else begin
      state   <= state_nxt;
      mc_busy <= mc_row;
      timer   <= timer_nxt;
    end
  end

  always_comb begin
    state_nxt = ST_RUN;
    timer_nxt = '0;
    if (mem_stay) begin
      state_nxt = ST_MEM_WAIT;
    end else if (mc_row) begin
      state_nxt = ST_MC_WAIT;
    end
    if (in_mem && mem_stay) begin
      timer_nxt = timer + 1'b1;
    end
  end

  // Strict priority: memory wait, mul/div wait, redirect, load-use
  always_comb begin
    pipe_ctrl   = CTRL_IDLE;
    pc_pause    = 1'b0;
    mem_timeout = 1'b0;
    if (rst) begin
      pipe_ctrl = CTRL_RESET;
      pc_pause  = 1'b1;
    end else if (mem_row) begin
      pipe_ctrl   = CTRL_MEMWAIT;
      pc_pause    = 1'b1;
      mem_timeout = tmo_hit;
    end else if (mc_row) begin
      pipe_ctrl = CTRL_MCWAIT;
      pc_pause  = 1'b1;
    end else if (redir_row) begin
      pipe_ctrl = CTRL_REDIR;
    end else if (lduse_row) begin
      pipe_ctrl = CTRL_LDUSE;
      pc_pause  = 1'b1;
    end
  end

  assign st_dbg = state;

`ifdef PIPE_STALL_CTRL_PERF_EN
  logic stall_evt, flush_evt;

  assign stall_evt = ~rst & pc_pause;
  assign flush_evt = ~rst & ~mem_row & ~mc_row & redir_row;

  pipe_stall_ctrl_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_evt),
    .count (perf_stall_cyc)
  );

  pipe_stall_ctrl_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_evt),
    .count (perf_flush_cnt)
  );
`endif

endmodule
